// File: rtl/dcache_port_pkg.sv
// Package shared by the data-cache port controller and its way/word mux.
// Contents:
//   dcache_port_state_e  controller FSM states
//   req_t                captured core request {we, index, be, wdata, tag}
//   WORD_OFF_W           width of the 64-bit word offset within a cache line
// The struct field widths follow the DP_* localparams below. A top-level instance
// that overrides INDEX_WIDTH/TAG_WIDTH/LINE_WIDTH needs these localparams to match.
package dcache_port_pkg;

    localparam int unsigned DP_INDEX_WIDTH = 12;
    localparam int unsigned DP_TAG_WIDTH   = 44;
    localparam int unsigned DP_LINE_WIDTH  = 128;

    // A 64-bit line still gets one offset bit so no signal collapses to zero width.
    localparam int unsigned WORD_OFF_W =
        (DP_LINE_WIDTH > 64) ? $clog2(DP_LINE_WIDTH / 64) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StTagCmp,
        StWrHit,
        StMissReq,
        StMissWait
    } dcache_port_state_e;

    typedef struct packed {
        logic                      we;
        logic [DP_INDEX_WIDTH-1:0] index;
        logic [7:0]                be;
        logic [63:0]               wdata;
        logic [DP_TAG_WIDTH-1:0]   tag;
    } req_t;

endpackage

// File: rtl/dcache_way_word_mux.sv
// Way/word read mux for the data-cache port controller. Purely combinational.
// Ports:
//   way_sel_i    one-hot (or zero) way select; a multi-hot select ORs the ways together
//   line_data_i  per-way line data, way w at [w*LINE_WIDTH +: LINE_WIDTH]
//   word_off_i   64-bit word offset within the selected line
//   word_o       selected 64-bit word (0 when no way is selected)
module dcache_way_word_mux #(
    parameter int unsigned SET_ASSOC  = 8,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned WORD_OFF_W = 1
) (
    input  logic [SET_ASSOC-1:0]            way_sel_i,
    input  logic [SET_ASSOC*LINE_WIDTH-1:0] line_data_i,
    input  logic [WORD_OFF_W-1:0]           word_off_i,
    output logic [63:0]                     word_o
);

    localparam int unsigned WORDS = LINE_WIDTH / 64;

    logic [LINE_WIDTH-1:0] w_line;

    always_comb begin
        // AND-OR mux: no priority between ways.
        w_line = '0;
        for (int w = 0; w < SET_ASSOC; w++) begin
            if (way_sel_i[w]) begin
                w_line = w_line | line_data_i[w*LINE_WIDTH +: LINE_WIDTH];
            end
        end
        word_o = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (32'(word_off_i) == k) begin
                word_o = w_line[k*64 +: 64];
            end
        end
    end

endmodule

// File: rtl/dcache_port_ctrl.sv
// Per-port data-cache request controller, upstream of the tag-compare/arbiter stage.
// One core load/store is accepted at a time: index phase to the tag stage, late tag one
// cycle after grant, then load-hit data return, store-hit write, or hand-off to the miss unit.
// Ports:
//   core side : req_i/we_i/index_i/be_i/wdata_i -> gnt_o; tag_i/tag_valid_i/kill_i;
//               rvalid_o/rdata_o load return (registered, 1-cycle pulse)
//   tag stage : tc_req_o/tc_addr_o/tc_we_o/tc_be_o/tc_wdata_o/tc_tag_o out,
//               tc_gnt_i/tc_hit_way_i/tc_rdata_i in
//   miss unit : miss_req_o/miss_we_o/miss_addr_o/miss_be_o/miss_wdata_o out,
//               miss_gnt_i/miss_valid_i/miss_rdata_i in
// Build option DCACHE_PORT_CTRL_PERF_EN: adds hit_cnt_o/miss_cnt_o, counting resolved
// non-killed tag compares (wrapping 32-bit).
module dcache_port_ctrl
    import dcache_port_pkg::*;
#(
    parameter int unsigned SET_ASSOC   = 8,
    parameter int unsigned INDEX_WIDTH = DP_INDEX_WIDTH,
    parameter int unsigned TAG_WIDTH   = DP_TAG_WIDTH,
    parameter int unsigned LINE_WIDTH  = DP_LINE_WIDTH,
    parameter int unsigned ADDR_WIDTH  = TAG_WIDTH + INDEX_WIDTH
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_i,
    input  logic                            we_i,
    input  logic [INDEX_WIDTH-1:0]          index_i,
    input  logic [7:0]                      be_i,
    input  logic [63:0]                     wdata_i,
    output logic                            gnt_o,
    input  logic [TAG_WIDTH-1:0]            tag_i,
    input  logic                            tag_valid_i,
    input  logic                            kill_i,
    output logic                            rvalid_o,
    output logic [63:0]                     rdata_o,
    output logic [SET_ASSOC-1:0]            tc_req_o,
    output logic [INDEX_WIDTH-1:0]          tc_addr_o,
    output logic                            tc_we_o,
    output logic [LINE_WIDTH/8-1:0]         tc_be_o,
    output logic [LINE_WIDTH-1:0]           tc_wdata_o,
    input  logic                            tc_gnt_i,
    output logic [TAG_WIDTH-1:0]            tc_tag_o,
    input  logic [SET_ASSOC-1:0]            tc_hit_way_i,
    input  logic [SET_ASSOC*LINE_WIDTH-1:0] tc_rdata_i,
    output logic                            miss_req_o,
    output logic                            miss_we_o,
    output logic [ADDR_WIDTH-1:0]           miss_addr_o,
    output logic [7:0]                      miss_be_o,
    output logic [63:0]                     miss_wdata_o,
    input  logic                            miss_gnt_i,
    input  logic                            miss_valid_i,
    input  logic [63:0]                     miss_rdata_i
`ifdef DCACHE_PORT_CTRL_PERF_EN
    ,
    output logic [31:0]                     hit_cnt_o,
    output logic [31:0]                     miss_cnt_o
`endif
);

    localparam int unsigned WORDS = LINE_WIDTH / 64;
    localparam int unsigned BE_W  = LINE_WIDTH / 8;

    dcache_port_state_e   r_state, w_state_d;
    req_t                 r_req, w_req_d;
    logic [SET_ASSOC-1:0] r_way, w_way_d;
    logic                 r_rvalid, w_rvalid_d;
    logic [63:0]          r_rdata, w_rdata_d;

    logic [WORD_OFF_W-1:0] w_word_off;
    logic [63:0]           w_hit_word;
    logic                  w_hit;
    logic                  w_cmp_done;

    // Word offset sits just above the byte-in-word bits of the captured index.
    assign w_word_off = (LINE_WIDTH > 64) ? r_req.index[3 +: WORD_OFF_W] : '0;
    assign w_hit      = |tc_hit_way_i;
    assign w_cmp_done = (r_state == StTagCmp) && tag_valid_i && !kill_i;

    dcache_way_word_mux #(
        .SET_ASSOC  (SET_ASSOC),
        .LINE_WIDTH (LINE_WIDTH),
        .WORD_OFF_W (WORD_OFF_W)
    ) u_way_word_mux (
        .way_sel_i   (tc_hit_way_i),
        .line_data_i (tc_rdata_i),
        .word_off_i  (w_word_off),
        .word_o      (w_hit_word)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= StIdle;
            r_req    <= '0;
            r_way    <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_d;
            r_req    <= w_req_d;
            r_way    <= w_way_d;
            r_rvalid <= w_rvalid_d;
            r_rdata  <= w_rdata_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_req_d      = r_req;
        w_way_d      = r_way;
        w_rvalid_d   = 1'b0;
        w_rdata_d    = r_rdata;
        gnt_o        = 1'b0;
        tc_req_o     = '0;
        tc_addr_o    = '0;
        tc_we_o      = 1'b0;
        tc_be_o      = '0;
        tc_wdata_o   = '0;
        tc_tag_o     = '0;
        miss_req_o   = 1'b0;
        miss_we_o    = 1'b0;
        miss_addr_o  = '0;
        miss_be_o    = '0;
        miss_wdata_o = '0;

        unique case (r_state)
            StIdle: begin
                if (req_i) begin
                    tc_req_o  = '1;
                    tc_addr_o = index_i;
                end
                gnt_o = tc_gnt_i;
                if (req_i && tc_gnt_i) begin
                    w_req_d.we    = we_i;
                    w_req_d.index = index_i;
                    w_req_d.be    = be_i;
                    w_req_d.wdata = wdata_i;
                    w_state_d     = StTagCmp;
                end
            end
            StTagCmp: begin
                tc_tag_o  = tag_i;
                tc_addr_o = r_req.index;
                if (kill_i) begin
                    w_state_d = StIdle;
                end else if (!tag_valid_i) begin
                    // Tag stage output is consumed on read, so keep requesting until the tag shows.
                    tc_req_o = '1;
                end else begin
                    w_req_d.tag = tag_i;
                    if (!w_hit) begin
                        w_state_d = StMissReq;
                    end else if (r_req.we) begin
                        w_way_d   = tc_hit_way_i;
                        w_state_d = StWrHit;
                    end else begin
                        w_rvalid_d = 1'b1;
                        w_rdata_d  = w_hit_word;
                        w_state_d  = StIdle;
                    end
                end
            end
            StWrHit: begin
                tc_req_o   = r_way;
                tc_addr_o  = r_req.index;
                tc_we_o    = 1'b1;
                tc_tag_o   = r_req.tag;
                tc_be_o    = BE_W'(r_req.be) << (32'(w_word_off) * 8);
                tc_wdata_o = {WORDS{r_req.wdata}};
                if (tc_gnt_i) begin
                    w_state_d = StIdle;
                end
            end
            StMissReq: begin
                miss_req_o   = 1'b1;
                miss_we_o    = r_req.we;
                miss_addr_o  = {r_req.tag, r_req.index};
                miss_be_o    = r_req.be;
                miss_wdata_o = r_req.wdata;
                if (miss_gnt_i) begin
                    if (miss_valid_i) begin
                        w_rvalid_d = !r_req.we;
                        if (!r_req.we) begin
                            w_rdata_d = miss_rdata_i;
                        end
                        w_state_d = StIdle;
                    end else begin
                        w_state_d = StMissWait;
                    end
                end
            end
            StMissWait: begin
                if (miss_valid_i) begin
                    w_rvalid_d = !r_req.we;
                    if (!r_req.we) begin
                        w_rdata_d = miss_rdata_i;
                    end
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;

`ifdef DCACHE_PORT_CTRL_PERF_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_cmp_done) begin
            if (w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`else
    logic w_unused_cmp_done;
    assign w_unused_cmp_done = w_cmp_done;
`endif

endmodule

// File: tb/tb_dcache_port_ctrl.sv
// Directed self-checking bench for dcache_port_ctrl.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Build option DCACHE_PORT_CTRL_PERF_EN also enables the performance counter checks.
module tb_dcache_port_ctrl;

    logic          clk_i;
    logic          rst_ni;
    logic          req_i;
    logic          we_i;
    logic [11:0]   index_i;
    logic [7:0]    be_i;
    logic [63:0]   wdata_i;
    logic          gnt_o;
    logic [43:0]   tag_i;
    logic          tag_valid_i;
    logic          kill_i;
    logic          rvalid_o;
    logic [63:0]   rdata_o;
    logic [7:0]    tc_req_o;
    logic [11:0]   tc_addr_o;
    logic          tc_we_o;
    logic [15:0]   tc_be_o;
    logic [127:0]  tc_wdata_o;
    logic          tc_gnt_i;
    logic [43:0]   tc_tag_o;
    logic [7:0]    tc_hit_way_i;
    logic [1023:0] tc_rdata_i;
    logic          miss_req_o;
    logic          miss_we_o;
    logic [55:0]   miss_addr_o;
    logic [7:0]    miss_be_o;
    logic [63:0]   miss_wdata_o;
    logic          miss_gnt_i;
    logic          miss_valid_i;
    logic [63:0]   miss_rdata_i;
`ifdef DCACHE_PORT_CTRL_PERF_EN
    logic [31:0]   hit_cnt_o;
    logic [31:0]   miss_cnt_o;
`endif

    int nc = 0;
    int nf = 0;

    dcache_port_ctrl u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .we_i         (we_i),
        .index_i      (index_i),
        .be_i         (be_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .tag_i        (tag_i),
        .tag_valid_i  (tag_valid_i),
        .kill_i       (kill_i),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .tc_req_o     (tc_req_o),
        .tc_addr_o    (tc_addr_o),
        .tc_we_o      (tc_we_o),
        .tc_be_o      (tc_be_o),
        .tc_wdata_o   (tc_wdata_o),
        .tc_gnt_i     (tc_gnt_i),
        .tc_tag_o     (tc_tag_o),
        .tc_hit_way_i (tc_hit_way_i),
        .tc_rdata_i   (tc_rdata_i),
        .miss_req_o   (miss_req_o),
        .miss_we_o    (miss_we_o),
        .miss_addr_o  (miss_addr_o),
        .miss_be_o    (miss_be_o),
        .miss_wdata_o (miss_wdata_o),
        .miss_gnt_i   (miss_gnt_i),
        .miss_valid_i (miss_valid_i),
        .miss_rdata_i (miss_rdata_i)
`ifdef DCACHE_PORT_CTRL_PERF_EN
        ,
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_i        = 1'b0;
        we_i         = 1'b0;
        index_i      = '0;
        be_i         = '0;
        wdata_i      = '0;
        tag_i        = '0;
        tag_valid_i  = 1'b0;
        kill_i       = 1'b0;
        tc_gnt_i     = 1'b0;
        tc_hit_way_i = '0;
        miss_gnt_i   = 1'b0;
        miss_valid_i = 1'b0;
        miss_rdata_i = '0;
    endtask

    // Way w, word k holds 64'hA000_0000_0000_00wk, except way 3 which holds DEAD/BEEF.
    task automatic fill_lines();
        for (int w = 0; w < 8; w++) begin
            for (int k = 0; k < 2; k++) begin
                tc_rdata_i[w*128 + k*64 +: 64] = 64'hA000_0000_0000_0000 | 64'(w * 16 + k);
            end
        end
        tc_rdata_i[3*128 +: 64]      = 64'hDEAD;
        tc_rdata_i[3*128 + 64 +: 64] = 64'hBEEF;
    endtask

    task automatic test_reset();
        #2;
        nc++; if ({gnt_o, rvalid_o, tc_we_o, miss_req_o, miss_we_o} !== 5'b0) begin
            nf++; $display("FAIL rst_ctl got %b want 00000",
                           {gnt_o, rvalid_o, tc_we_o, miss_req_o, miss_we_o}); end
        nc++; if ({rdata_o, tc_req_o, tc_addr_o, tc_be_o, miss_addr_o} !== '0) begin
            nf++; $display("FAIL rst_data got rdata=%h tc_req=%h miss_addr=%h want 0",
                           rdata_o, tc_req_o, miss_addr_o); end
`ifdef DCACHE_PORT_CTRL_PERF_EN
        nc++; if ({hit_cnt_o, miss_cnt_o} !== 64'h0) begin
            nf++; $display("FAIL rst_cnt got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o); end
`endif
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();
    endtask

    task automatic test_load_hit();
        logic [11:0] idx [2];
        logic [7:0]  hw  [2];
        logic [63:0] exp [2];
        idx[0] = 12'h040; hw[0] = 8'h08; exp[0] = 64'hDEAD;
        idx[1] = 12'h048; hw[1] = 8'h40; exp[1] = 64'hA000_0000_0000_0061;
        for (int v = 0; v < 2; v++) begin
            req_i = 1'b1; we_i = 1'b0; index_i = idx[v]; tc_gnt_i = 1'b1;
            @(negedge clk_i);
            nc++; if (gnt_o !== 1'b1) begin
                nf++; $display("FAIL lh_gnt[%0d] got %b want 1", v, gnt_o); end
            nc++; if ({tc_req_o, tc_addr_o, tc_we_o} !== {8'hFF, idx[v], 1'b0}) begin
                nf++; $display("FAIL lh_index[%0d] got req=%h addr=%h we=%b want FF %h 0",
                               v, tc_req_o, tc_addr_o, tc_we_o, idx[v]); end
            next_cycle();
            req_i = 1'b0; tag_i = 44'h1A; tag_valid_i = 1'b1; tc_hit_way_i = hw[v];
            @(negedge clk_i);
            nc++; if (tc_tag_o !== 44'h1A) begin
                nf++; $display("FAIL lh_tag[%0d] got %h want 1a", v, tc_tag_o); end
            nc++; if ({gnt_o, rvalid_o, tc_req_o} !== 10'b0) begin
                nf++; $display("FAIL lh_tagcyc[%0d] got gnt=%b rv=%b req=%h want 0 0 00",
                               v, gnt_o, rvalid_o, tc_req_o); end
            next_cycle();
            tc_gnt_i = 1'b0; tag_valid_i = 1'b0; tc_hit_way_i = '0;
            @(negedge clk_i);
            nc++; if ({rvalid_o, rdata_o} !== {1'b1, exp[v]}) begin
                nf++; $display("FAIL lh_data[%0d] got rv=%b %h want 1 %h",
                               v, rvalid_o, rdata_o, exp[v]); end
            next_cycle();
            @(negedge clk_i);
            nc++; if (rvalid_o !== 1'b0) begin
                nf++; $display("FAIL lh_pulse[%0d] got %b want 0", v, rvalid_o); end
            next_cycle();
        end
    endtask

    task automatic test_store_hit();
        req_i = 1'b1; we_i = 1'b1; index_i = 12'h048; be_i = 8'h0F;
        wdata_i = 64'h1122_3344_5566_7788; tc_gnt_i = 1'b1;
        next_cycle();
        idle_inputs();
        tag_i = 44'h77; tag_valid_i = 1'b1; tc_hit_way_i = 8'h20;
        next_cycle();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) tc_gnt_i = 1'b1;
            @(negedge clk_i);
            nc++; if ({tc_we_o, tc_req_o, tc_be_o, tc_addr_o} !== {1'b1, 8'h20, 16'h0F00, 12'h048})
            begin
                nf++; $display("FAIL sh_write[%0d] got we=%b req=%h be=%h addr=%h want 1 20 0f00 048",
                               c, tc_we_o, tc_req_o, tc_be_o, tc_addr_o); end
            nc++; if (tc_wdata_o !== 128'h1122_3344_5566_7788_1122_3344_5566_7788) begin
                nf++; $display("FAIL sh_wdata[%0d] got %h", c, tc_wdata_o); end
            nc++; if ({rvalid_o, miss_req_o} !== 2'b00) begin
                nf++; $display("FAIL sh_side[%0d] got rv=%b miss=%b want 0 0",
                               c, rvalid_o, miss_req_o); end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk_i);
        nc++; if ({tc_we_o, tc_req_o} !== 9'b0) begin
            nf++; $display("FAIL sh_done got we=%b req=%h want 0 00", tc_we_o, tc_req_o); end
        next_cycle();
    endtask

    task automatic test_load_miss();
        req_i = 1'b1; we_i = 1'b0; index_i = 12'h100; tc_gnt_i = 1'b1;
        next_cycle();
        idle_inputs();
        tag_i = 44'h2B; tag_valid_i = 1'b1; tc_hit_way_i = 8'h00;
        next_cycle();
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            if (c == 3) miss_gnt_i = 1'b1;
            @(negedge clk_i);
            nc++; if ({miss_req_o, miss_we_o, miss_addr_o} !== {1'b1, 1'b0, 56'h2B100}) begin
                nf++; $display("FAIL lm_req[%0d] got req=%b we=%b addr=%h want 1 0 2b100",
                               c, miss_req_o, miss_we_o, miss_addr_o); end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk_i);
        nc++; if ({miss_req_o, rvalid_o} !== 2'b00) begin
            nf++; $display("FAIL lm_wait got req=%b rv=%b want 0 0", miss_req_o, rvalid_o); end
        next_cycle();
        miss_valid_i = 1'b1; miss_rdata_i = 64'h55;
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        nc++; if ({rvalid_o, rdata_o} !== {1'b1, 64'h55}) begin
            nf++; $display("FAIL lm_data got rv=%b %h want 1 55", rvalid_o, rdata_o); end
        next_cycle();
    endtask

    task automatic test_kill();
        req_i = 1'b1; we_i = 1'b0; index_i = 12'h040; tc_gnt_i = 1'b1;
        next_cycle();
        idle_inputs();
        tag_i = 44'h1A; tag_valid_i = 1'b1; tc_hit_way_i = 8'h01; kill_i = 1'b1;
        next_cycle();
        idle_inputs();
        req_i = 1'b1; index_i = 12'h000; tc_gnt_i = 1'b1;
        @(negedge clk_i);
        nc++; if ({rvalid_o, miss_req_o, gnt_o} !== 3'b001) begin
            nf++; $display("FAIL kill_abort got rv=%b miss=%b gnt=%b want 0 0 1",
                           rvalid_o, miss_req_o, gnt_o); end
        next_cycle();
        idle_inputs();
        tag_i = 44'h5; tag_valid_i = 1'b1; tc_hit_way_i = 8'h01;
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        nc++; if ({rvalid_o, rdata_o} !== {1'b1, 64'hA000_0000_0000_0000}) begin
            nf++; $display("FAIL kill_next got rv=%b %h want 1 a000000000000000",
                           rvalid_o, rdata_o); end
        next_cycle();
    endtask

    task automatic test_gnt_stall();
        req_i = 1'b1; we_i = 1'b0; index_i = 12'h2A0; tc_gnt_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            nc++; if ({gnt_o, tc_req_o, tc_addr_o} !== {1'b0, 8'hFF, 12'h2A0}) begin
                nf++; $display("FAIL stall[%0d] got gnt=%b req=%h addr=%h want 0 ff 2a0",
                               c, gnt_o, tc_req_o, tc_addr_o); end
            next_cycle();
        end
        tc_gnt_i = 1'b1;
        @(negedge clk_i);
        nc++; if (gnt_o !== 1'b1) begin
            nf++; $display("FAIL stall_gnt got %b want 1", gnt_o); end
        next_cycle();
        idle_inputs();
        kill_i = 1'b1;
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        nc++; if ({rvalid_o, miss_req_o, tc_req_o} !== 10'b0) begin
            nf++; $display("FAIL stall_kill got rv=%b miss=%b req=%h want 0 0 00",
                           rvalid_o, miss_req_o, tc_req_o); end
        next_cycle();
    endtask

    task automatic test_tag_wait();
        req_i = 1'b1; we_i = 1'b0; index_i = 12'h3F8; tc_gnt_i = 1'b1;
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        nc++; if ({tc_req_o, tc_addr_o, rvalid_o} !== {8'hFF, 12'h3F8, 1'b0}) begin
            nf++; $display("FAIL tw_reissue got req=%h addr=%h rv=%b want ff 3f8 0",
                           tc_req_o, tc_addr_o, rvalid_o); end
        next_cycle();
        tag_i = 44'h9; tag_valid_i = 1'b1; tc_hit_way_i = 8'h80;
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        nc++; if ({rvalid_o, rdata_o} !== {1'b1, 64'hA000_0000_0000_0071}) begin
            nf++; $display("FAIL tw_data got rv=%b %h want 1 a000000000000071",
                           rvalid_o, rdata_o); end
        next_cycle();
    endtask

    task automatic test_miss_fast();
        req_i = 1'b1; we_i = 1'b0; index_i = 12'h010; tc_gnt_i = 1'b1;
        next_cycle();
        idle_inputs();
        tag_i = 44'h4; tag_valid_i = 1'b1;
        next_cycle();
        idle_inputs();
        miss_gnt_i = 1'b1; miss_valid_i = 1'b1; miss_rdata_i = 64'h77;
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        nc++; if ({rvalid_o, rdata_o, miss_req_o} !== {1'b1, 64'h77, 1'b0}) begin
            nf++; $display("FAIL mf_data got rv=%b %h miss=%b want 1 77 0",
                           rvalid_o, rdata_o, miss_req_o); end
        next_cycle();
    endtask

`ifdef DCACHE_PORT_CTRL_PERF_EN
    task automatic test_perf_counters();
        @(negedge clk_i);
        nc++; if ({hit_cnt_o, miss_cnt_o} !== {32'd5, 32'd2}) begin
            nf++; $display("FAIL perf_cnt got %0d/%0d want 5/2", hit_cnt_o, miss_cnt_o); end
        next_cycle();
    endtask
`endif

    task automatic test_reset_mid_miss();
        req_i = 1'b1; we_i = 1'b1; index_i = 12'h0F0; be_i = 8'hF0;
        wdata_i = 64'hCAFE; tc_gnt_i = 1'b1;
        next_cycle();
        idle_inputs();
        tag_i = 44'h3C; tag_valid_i = 1'b1;
        next_cycle();
        idle_inputs();
        miss_gnt_i = 1'b1;
        @(negedge clk_i);
        nc++; if ({miss_req_o, miss_we_o, miss_addr_o, miss_be_o, miss_wdata_o} !==
                  {1'b1, 1'b1, 56'h3C0F0, 8'hF0, 64'hCAFE}) begin
            nf++; $display("FAIL sm_req got req=%b we=%b addr=%h be=%h wd=%h",
                           miss_req_o, miss_we_o, miss_addr_o, miss_be_o, miss_wdata_o); end
        next_cycle();
        idle_inputs();
        #1;
        rst_ni = 1'b0;
        #1;
        nc++; if ({miss_req_o, rvalid_o, rdata_o, tc_req_o, tc_we_o, gnt_o} !== '0) begin
            nf++; $display("FAIL rst_mid got miss=%b rv=%b rdata=%h req=%h",
                           miss_req_o, rvalid_o, rdata_o, tc_req_o); end
`ifdef DCACHE_PORT_CTRL_PERF_EN
        nc++; if ({hit_cnt_o, miss_cnt_o} !== 64'h0) begin
            nf++; $display("FAIL rst_mid_cnt got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o); end
`endif
        next_cycle();
        rst_ni = 1'b1;
        miss_valid_i = 1'b1; miss_rdata_i = 64'h99;
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        nc++; if ({rvalid_o, miss_req_o} !== 2'b00) begin
            nf++; $display("FAIL rst_after got rv=%b miss=%b want 0 0", rvalid_o, miss_req_o); end
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        tc_rdata_i = '0;
        fill_lines();
        test_reset();
        test_load_hit();
        test_store_hit();
        test_load_miss();
        test_kill();
        test_gnt_stall();
        test_tag_wait();
        test_miss_fast();
`ifdef DCACHE_PORT_CTRL_PERF_EN
        test_perf_counters();
`endif
        test_reset_mid_miss();
        $display("End of test - %0d assertions evaluated, %0d failures", nc, nf);
        $finish;
    end

endmodule
